// File: rtl/move_collector_pkg.sv
// Shared chess definitions: square/slot geometry, collector FSM encoding and slot helpers.
package move_collector_pkg;

  localparam int COORD_W    = 3;
  localparam int SQ_W       = 2 * COORD_W;
  localparam int SLOT_W     = 6;
  localparam int SLOT_N     = 8;
  localparam int SLOT_IDX_W = 3;
  localparam int WORD_W     = SLOT_W * SLOT_N;
  localparam int MOVE_W     = 2 * SQ_W;
  localparam int CNT_W      = 8;

  typedef logic [SQ_W-1:0]   square_t;
  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam square_t SQ_LAST   = 6'd63;
  localparam slot_t   SLOT_NONE = 6'o00;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  function automatic slot_t slot_at(input word_t w, input logic [SLOT_IDX_W-1:0] i);
    return w[int'(i)*SLOT_W +: SLOT_W];
  endfunction

endpackage

// File: rtl/move_collector_slot_pick.sv
// Highest-index set bit of the non-empty slot mask.
module slot_pick
  import move_collector_pkg::*;
(
  input  logic [SLOT_N-1:0]     mask,
  output logic [SLOT_IDX_W-1:0] idx,
  output logic                  any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < SLOT_N; i++) begin
      if (mask[i]) begin
        idx = i[SLOT_IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_collector.sv
// Walks all 64 square FIFOs once the square units finish and streams every
// pseudo-move {src, dst} out through a valid/ready handshake.
module move_collector
  import move_collector_pkg::*;
#(
  parameter int MAX_MOVES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              all_done,
  output logic [SQ_W-1:0]   sq_sel,
  input  logic              sq_empty,
  input  logic [WORD_W-1:0] sq_word,
  output logic              sq_rd,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [MOVE_W-1:0] mv_data,
  output logic [CNT_W-1:0]  mv_count,
  output logic              busy,
  output logic              list_done,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

  logic [2:0]            state;
  logic                  all_done_p1;
  word_t                 slot_reg;
  logic [SLOT_N-1:0]     live;
  logic [SLOT_IDX_W-1:0] pick;
  logic                  any;
  logic                  hs;
  logic                  cnt_sat;
  logic [CNT_W-1:0]      cnt_nxt;

  // Saturating move counter: returns {hit_limit, next_count}.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == MAX_CNT) return {1'b1, c};
    return {1'b0, c + 1'b1};
  endfunction

  always_comb begin
    live = '0;
    for (int i = 0; i < SLOT_N; i++) begin
      live[i] = (slot_at(slot_reg, i[SLOT_IDX_W-1:0]) != SLOT_NONE) &&
                (slot_at(slot_reg, i[SLOT_IDX_W-1:0]) != sq_sel);
    end
  end

  slot_pick u_pick (
    .mask (live),
    .idx  (pick),
    .any  (any)
  );

  assign mv_valid  = (state == S_EMIT) && any;
  assign mv_data   = mv_valid ? {slot_at(slot_reg, pick), sq_sel} : '0;
  assign hs        = mv_valid && mv_ready;
  // Pop is suppressed during reset so an abandoned list never loses a FIFO word.
  assign sq_rd     = (state == S_LOAD) && !sq_empty && !reset;
  assign busy      = (state == S_WAIT) || (state == S_LOAD) ||
                     (state == S_EMIT) || (state == S_NEXT);
  assign list_done = (state == S_FIN);
  assign {cnt_sat, cnt_nxt} = sat_inc(mv_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sq_sel      <= '0;
      slot_reg    <= '0;
      mv_count    <= '0;
      overflow    <= 1'b0;
      all_done_p1 <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            state       <= S_WAIT;
            sq_sel      <= '0;
            mv_count    <= '0;
            overflow    <= 1'b0;
            all_done_p1 <= 1'b0;
          end
        end
        // all_done lags the square units by one register, so require two in a row.
        S_WAIT: begin
          all_done_p1 <= all_done;
          if (all_done && all_done_p1) state <= S_LOAD;
        end
        S_LOAD: begin
          if (sq_empty) begin
            state <= S_NEXT;
          end else begin
            slot_reg <= sq_word;
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (!any) begin
            state <= S_LOAD;
          end else if (hs) begin
            slot_reg[int'(pick)*SLOT_W +: SLOT_W] <= SLOT_NONE;
            if (cnt_sat) overflow <= 1'b1;
            else         mv_count <= cnt_nxt;
          end
        end
        S_NEXT: begin
          if (sq_sel == SQ_LAST) begin
            state <= S_FIN;
          end else begin
            sq_sel <= sq_sel + 1'b1;
            state  <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (all logic on rising edge).
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse that begins collection for a new board.
REQ-004 SHALL have ports: all_done  in  1  AND of the done outputs of all 64 square units.
REQ-005 SHALL have ports: sq_sel  out  6  selected square {x[2:0],y[2:0]} driving the external 64:1 FIFO mux.
REQ-006 SHALL have ports: sq_empty  in  1  FIFO of the selected square is empty; sq_word  in  48  head word of the selected FIFO.
REQ-007 SHALL have ports: sq_rd  out  1  one-cycle pop of the selected FIFO.
REQ-008 SHALL have ports: mv_valid  out  1 / mv_ready  in  1 / mv_data  out  12  move {src x,y, dst x,y}.
REQ-009 SHALL have ports: mv_count  out  8  moves emitted; busy  out  1; list_done  out  1  level; overflow  out  1  sticky.
REQ-010 Parameter MAX_MOVES, default 255, meaning the list capacity; mv_count saturates at it.

Function
REQ-011 sq_word and sq_empty SHALL be combinational from sq_sel, valid in the same cycle; after sq_rd the next head is valid the following cycle.
REQ-012 sq_word SHALL be decoded as 8 slots of 6 bits, slot 7 = bits 47:42 down to slot 0 = bits 5:0; each slot holds an origin square {x,y}.
REQ-013 A slot SHALL be empty when it is 6'o00 or equal to sq_sel; empty slots produce no move.
REQ-014 FSM states SHALL be IDLE, WAIT, LOAD, EMIT, NEXT, FIN.
REQ-015 IDLE: on start -> WAIT; clear mv_count, overflow, list_done; sq_sel=0.
REQ-016 WAIT: stay until all_done=1 held for 2 consecutive cycles -> LOAD (the done signal lags by one register stage).
REQ-017 LOAD: if sq_empty -> NEXT; else latch sq_word into a 48-bit slot register, assert sq_rd for exactly that cycle, -> EMIT.
REQ-018 EMIT: present the highest-index non-empty remaining slot as mv_data={slot, sq_sel}, mv_valid=1; on mv_valid&mv_ready clear that slot, increment mv_count; when no non-empty slot remains -> LOAD (same square, next FIFO word).
REQ-019 mv_data SHALL be stable while mv_valid=1 and mv_ready=0; mv_valid SHALL NOT drop without a handshake.
REQ-020 An all-empty latched word SHALL spend 1 cycle in EMIT with mv_valid=0, then -> LOAD.
REQ-021 NEXT: if sq_sel==63 -> FIN; else sq_sel+1 -> LOAD.
REQ-022 FIN: list_done=1, busy=0; hold until start (-> WAIT, same clearing as REQ-015).
REQ-023 busy SHALL be 1 in WAIT, LOAD, EMIT, NEXT.
REQ-024 When mv_count==MAX_MOVES, further moves SHALL still be handshaken and drained but not counted; overflow set to 1.
REQ-025 start in any state other than IDLE/FIN SHALL be ignored.
REQ-026 Minimum throughput SHALL be one move per cycle while mv_ready=1 within a word.

Reset
REQ-027 reset SHALL force IDLE, sq_sel=0, sq_rd=0, mv_valid=0, mv_data=0, mv_count=0, busy=0, list_done=0, overflow=0, slot register=0.
REQ-028 reset mid-operation SHALL abandon the current list; no FIFO pop occurs in the reset cycle.

Structure
REQ-029 Square/coordinate widths, slot width (6), slot count (8), and FSM state encoding SHALL live in a shared chess package used with the square unit.
REQ-030 Highest-set-slot selection SHALL be one sub-module, slot_pick (8-bit non-empty mask in -> 3-bit index + any flag out).
REQ-031 The 64:1 FIFO mux SHALL be outside this block.

Verification
REQ-032 Square (4,2) holds one word with slot7=6'o41, slot0=6'o31, rest 0, mv_ready=1 -> mv_data 12'o4142 then 12'o3142, mv_count=2, list_done after sq_sel reaches 63.
REQ-033 Same stimulus, mv_ready toggled 1-0-0-1 -> mv_data held during stall, exactly 2 handshakes, no duplicates.
REQ-034 Square 0 with two FIFO words of 3 moves each -> 6 moves, sq_rd pulsed exactly twice on sq_sel=0.
REQ-035 all_done=1 for only 1 cycle then 0 -> FSM stays in WAIT, sq_rd never asserted.
REQ-036 Slot equal to sq_sel and slot 6'o00 present -> no move emitted for them.
REQ-037 300 moves available, MAX_MOVES=255 -> mv_count=255, overflow=1, all 300 handshaken; reset asserted mid-EMIT -> all outputs at REQ-027 values next cycle.
